// File: rtl/issue_request_gen_pkg.sv
// Shared issue-queue types: per-entry state struct and default widths.
package issue_request_gen_pkg;

  localparam int unsigned DEFAULT_SIZE_SELECT_BLOCK = 16;
  localparam int unsigned TAG_WIDTH                 = 7;

  typedef logic [TAG_WIDTH-1:0] tag_t;

  // One select-block slot: src index 1 is the upper tag/ready bit.
  typedef struct packed {
    logic           valid;
    logic [1:0]     src_rdy;
    tag_t [1:0]     src_tag;
  } entry_t;

endpackage

// File: rtl/issue_request_gen_if.sv
// Bundle between dispatch/wakeup/select-tree and the request generator.
// master: the request generator side; slave: the surrounding issue logic.
interface issue_request_gen_if #(
  parameter int unsigned SIZE_SELECT_BLOCK = issue_request_gen_pkg::DEFAULT_SIZE_SELECT_BLOCK
);
  import issue_request_gen_pkg::*;

  localparam int unsigned IDX_WIDTH = $clog2(SIZE_SELECT_BLOCK);

  logic                         alloc_valid_i;
  logic [IDX_WIDTH-1:0]         alloc_idx_i;
  logic [2*TAG_WIDTH-1:0]       alloc_tag_i;
  logic [1:0]                   alloc_rdy_i;
  logic                         wake_valid_i;
  logic [TAG_WIDTH-1:0]         wake_tag_i;
  logic [SIZE_SELECT_BLOCK-1:0] grant_i;
  logic                         flush_i;
  logic [SIZE_SELECT_BLOCK-1:0] req_o;
  logic [SIZE_SELECT_BLOCK-1:0] free_o;
  logic [IDX_WIDTH:0]           count_o;
  logic                         alloc_err_o;
  logic                         grant_err_o;

  modport master (
    input  alloc_valid_i, alloc_idx_i, alloc_tag_i, alloc_rdy_i,
    input  wake_valid_i, wake_tag_i, grant_i, flush_i,
    output req_o, free_o, count_o, alloc_err_o, grant_err_o
  );

  modport slave (
    output alloc_valid_i, alloc_idx_i, alloc_tag_i, alloc_rdy_i,
    output wake_valid_i, wake_tag_i, grant_i, flush_i,
    input  req_o, free_o, count_o, alloc_err_o, grant_err_o
  );

endinterface

// File: rtl/issue_request_entry.sv
// One issue-queue slot: entry state, two wakeup tag comparators, request equation.
module issue_request_entry
  import issue_request_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alloc_we,
  input  tag_t [1:0] alloc_tag,
  input  logic [1:0] alloc_rdy,
  input  logic       wake_valid,
  input  tag_t       wake_tag,
  input  logic       grant,
  input  logic       flush,
  output logic       req,
  output logic       valid
);

  entry_t     state_q;
  entry_t     state_d;
  logic [1:0] wake_hit;
  logic [1:0] alloc_hit;

  // Tag compare against the held sources and against the sources being written.
  always_comb begin
    wake_hit  = '0;
    alloc_hit = '0;
    for (int s = 0; s < 2; s++) begin
      wake_hit[s]  = wake_valid && (state_q.src_tag[s] == wake_tag);
      alloc_hit[s] = wake_valid && (alloc_tag[s] == wake_tag);
    end
  end

  // Next state: flush beats alloc, alloc beats grant-retire, else wakeup.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d.valid = 1'b0;
    end else if (alloc_we) begin
      state_d.valid   = 1'b1;
      state_d.src_tag = alloc_tag;
      state_d.src_rdy = alloc_rdy | alloc_hit;
    end else if (grant) begin
      state_d.valid = 1'b0;
    end else if (state_q.valid) begin
      state_d.src_rdy = state_q.src_rdy | wake_hit;
    end
  end

  // Entry state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign req   = state_q.valid & (&state_q.src_rdy);
  assign valid = state_q.valid;

endmodule

// File: rtl/issue_request_gen.sv
// Issue select-tree requester: per-slot entries, index decode, occupancy count,
// freed-slot pulses and error pulses.
// Optional macro REQ_GRANT_CHECK_EN enables the grant protocol checker
// (grant_err_o); without it grant_err_o is tied low.
module issue_request_gen
  import issue_request_gen_pkg::*;
#(
  parameter int unsigned SIZE_SELECT_BLOCK = DEFAULT_SIZE_SELECT_BLOCK
) (
  input logic                 clk,
  input logic                 reset,
  issue_request_gen_if.master bus
);

  localparam int unsigned IDX_WIDTH = $clog2(SIZE_SELECT_BLOCK);
  localparam int unsigned CNT_W     = IDX_WIDTH + 1;
  localparam int unsigned SUM_W     = IDX_WIDTH + 2;

  logic [SIZE_SELECT_BLOCK-1:0] req;
  logic [SIZE_SELECT_BLOCK-1:0] valid;
  logic [SIZE_SELECT_BLOCK-1:0] grant_acc;
  logic [SIZE_SELECT_BLOCK-1:0] alloc_we;
  logic                         alloc_ok;
  logic                         alloc_rej;
  logic [SUM_W-1:0]             grant_cnt;
  logic [SUM_W-1:0]             cnt_up;
  logic [CNT_W-1:0]             count_d;
  logic [CNT_W-1:0]             count_q;
  logic [SIZE_SELECT_BLOCK-1:0] free_d;
  logic [SIZE_SELECT_BLOCK-1:0] free_q;
  logic                         alloc_err_q;

  // Slot array.
  for (genvar i = 0; i < SIZE_SELECT_BLOCK; i++) begin : g_entry
    issue_request_entry u_entry (
      .clk        (clk),
      .rst_n      (reset),
      .alloc_we   (alloc_we[i]),
      .alloc_tag  (bus.alloc_tag_i),
      .alloc_rdy  (bus.alloc_rdy_i),
      .wake_valid (bus.wake_valid_i),
      .wake_tag   (bus.wake_tag_i),
      .grant      (grant_acc[i]),
      .flush      (bus.flush_i),
      .req        (req[i]),
      .valid      (valid[i])
    );
  end

  // Accepted grants and alloc decode; an occupied slot takes a new alloc only if it retires now.
  always_comb begin
    grant_acc = bus.grant_i & req;
    alloc_rej = bus.alloc_valid_i & ~bus.flush_i &
                valid[bus.alloc_idx_i] & ~grant_acc[bus.alloc_idx_i];
    alloc_ok  = bus.alloc_valid_i & ~bus.flush_i & ~alloc_rej;
    alloc_we  = '0;
    if (alloc_ok) begin
      alloc_we[bus.alloc_idx_i] = 1'b1;
    end
    free_d = bus.flush_i ? '0 : grant_acc;
  end

  // Occupancy update, saturating to 0..SIZE_SELECT_BLOCK.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < SIZE_SELECT_BLOCK; i++) begin
      grant_cnt = grant_cnt + SUM_W'(grant_acc[i]);
    end
    cnt_up = SUM_W'(count_q) + SUM_W'(alloc_ok);
    if (bus.flush_i || (cnt_up < grant_cnt)) begin
      count_d = '0;
    end else if ((cnt_up - grant_cnt) > SUM_W'(SIZE_SELECT_BLOCK)) begin
      count_d = CNT_W'(SIZE_SELECT_BLOCK);
    end else begin
      count_d = CNT_W'(cnt_up - grant_cnt);
    end
  end

  // Registered free pulses, count and alloc error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_q      <= '0;
      count_q     <= '0;
      alloc_err_q <= 1'b0;
    end else begin
      free_q      <= free_d;
      count_q     <= count_d;
      alloc_err_q <= alloc_rej;
    end
  end

`ifdef REQ_GRANT_CHECK_EN
  logic grant_err_d;
  logic grant_err_q;

  // Grant must be at most one-hot and only on requesting slots.
  always_comb begin
    grant_err_d = (|(bus.grant_i & (bus.grant_i - SIZE_SELECT_BLOCK'(1)))) |
                  (|(bus.grant_i & ~req));
  end

  // Registered protocol-error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_err_q <= 1'b0;
    end else begin
      grant_err_q <= grant_err_d;
    end
  end

  assign bus.grant_err_o = grant_err_q;
`else
  assign bus.grant_err_o = 1'b0;
`endif

  assign bus.req_o       = req;
  assign bus.free_o      = free_q;
  assign bus.count_o     = count_q;
  assign bus.alloc_err_o = alloc_err_q;

endmodule

// File: tb/tb_issue_request_gen.sv
// Bench for issue_request_gen: directed vector table, random run against a
// slot-array model, and an asynchronous reset check.
module tb_issue_request_gen;

  localparam int N = 16;
`ifdef REQ_GRANT_CHECK_EN
  localparam bit GE = 1'b1;
`else
  localparam bit GE = 1'b0;
`endif

  typedef struct {
    logic        av;
    logic [3:0]  idx;
    logic [6:0]  t1;
    logic [6:0]  t0;
    logic [1:0]  rdy;
    logic        wv;
    logic [6:0]  wt;
    logic [15:0] gnt;
    logic        fl;
    logic [15:0] e_req;
    logic [15:0] e_free;
    int          e_cnt;
    logic        e_aerr;
    logic        e_gerr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  // Model: slot array kept as plain arrays.
  bit       mv [N];
  bit [1:0] mr [N];
  bit [6:0] mt [N][2];

  issue_request_gen_if bus ();

  issue_request_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] idx, input logic [6:0] t1,
                       input logic [6:0] t0, input logic [1:0] rdy, input logic wv,
                       input logic [6:0] wt, input logic [15:0] gnt, input logic fl);
    bus.alloc_valid_i = av;
    bus.alloc_idx_i   = idx;
    bus.alloc_tag_i   = {t1, t0};
    bus.alloc_rdy_i   = rdy;
    bus.wake_valid_i  = wv;
    bus.wake_tag_i    = wt;
    bus.grant_i       = gnt;
    bus.flush_i       = fl;
  endtask

  function automatic logic [15:0] model_req();
    logic [15:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = mv[i] && (mr[i] == 2'b11);
    return r;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mv[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      mr[i] = 2'b00;
    end
  endtask

  // Apply the current bus inputs to the model as one clock edge.
  task automatic model_step(output logic [15:0] e_free, output logic e_aerr,
                            output logic e_gerr);
    logic [15:0] rq;
    logic [15:0] g;
    logic [15:0] acc;
    int          idx;
    rq     = model_req();
    g      = bus.grant_i;
    acc    = g & rq;
    idx    = int'(bus.alloc_idx_i);
    e_gerr = GE && (($countones(g) > 1) || ((g & ~rq) != 16'h0));
    e_aerr = 1'b0;
    e_free = 16'h0;
    if (bus.flush_i) begin
      model_clear();
    end else begin
      e_aerr = bus.alloc_valid_i && mv[idx] && !acc[idx];
      for (int i = 0; i < N; i++) begin
        if (mv[i] && bus.wake_valid_i) begin
          for (int s = 0; s < 2; s++)
            if (mt[i][s] == bus.wake_tag_i) mr[i][s] = 1'b1;
        end
        if (acc[i]) mv[i] = 1'b0;
      end
      if (bus.alloc_valid_i && !e_aerr) begin
        mv[idx]    = 1'b1;
        mt[idx][0] = bus.alloc_tag_i[6:0];
        mt[idx][1] = bus.alloc_tag_i[13:7];
        mr[idx]    = bus.alloc_rdy_i;
        for (int s = 0; s < 2; s++)
          if (bus.wake_valid_i && mt[idx][s] == bus.wake_tag_i) mr[idx][s] = 1'b1;
      end
      e_free = acc;
    end
  endtask

  task automatic edge_check(input string nm, input logic [15:0] er, input logic [15:0] ef,
                            input int ec, input logic ea, input logic eg);
    @(posedge clk);
    #1;
    chk({nm, " req"},   32'(bus.req_o),       32'(er));
    chk({nm, " free"},  32'(bus.free_o),      32'(ef));
    chk({nm, " count"}, 32'(bus.count_o),     32'(ec));
    chk({nm, " aerr"},  32'(bus.alloc_err_o), 32'(ea));
    chk({nm, " gerr"},  32'(bus.grant_err_o), 32'(eg));
  endtask

  function automatic vec_t mk(logic av, logic [3:0] idx, logic [6:0] t1, logic [6:0] t0,
                              logic [1:0] rdy, logic wv, logic [6:0] wt, logic [15:0] gnt,
                              logic fl, logic [15:0] er, logic [15:0] ef, int ec,
                              logic ea, logic eg);
    vec_t v;
    v.av = av; v.idx = idx; v.t1 = t1; v.t0 = t0; v.rdy = rdy; v.wv = wv; v.wt = wt;
    v.gnt = gnt; v.fl = fl; v.e_req = er; v.e_free = ef; v.e_cnt = ec;
    v.e_aerr = ea; v.e_gerr = eg;
    return v;
  endfunction

  vec_t        tbl[17];
  logic [15:0] m_free;
  logic        m_aerr;
  logic        m_gerr;

  initial begin
    //            av idx  t1  t0  rdy   wv wt  gnt       fl  req       free      cnt aerr gerr
    tbl[0]  = mk(1, 3,   2,  1, 2'b11, 0, 0,  16'h0000, 0, 16'h0008, 16'h0000, 1, 0, 0);
    tbl[1]  = mk(1, 5,  42, 10, 2'b01, 0, 0,  16'h0000, 0, 16'h0008, 16'h0000, 2, 0, 0);
    tbl[2]  = mk(0, 0,   0,  0, 2'b00, 0, 0,  16'h0000, 0, 16'h0008, 16'h0000, 2, 0, 0);
    tbl[3]  = mk(0, 0,   0,  0, 2'b00, 1, 42, 16'h0000, 0, 16'h0028, 16'h0000, 2, 0, 0);
    tbl[4]  = mk(1, 7,  20,  9, 2'b00, 1, 9,  16'h0000, 0, 16'h0028, 16'h0000, 3, 0, 0);
    tbl[5]  = mk(0, 0,   0,  0, 2'b00, 1, 20, 16'h0000, 0, 16'h00a8, 16'h0000, 3, 0, 0);
    tbl[6]  = mk(0, 0,   0,  0, 2'b00, 0, 0,  16'h0008, 0, 16'h00a0, 16'h0008, 2, 0, 0);
    tbl[7]  = mk(0, 0,   0,  0, 2'b00, 0, 0,  16'h0000, 0, 16'h00a0, 16'h0000, 2, 0, 0);
    tbl[8]  = mk(1, 5,   3,  3, 2'b00, 0, 0,  16'h0000, 0, 16'h00a0, 16'h0000, 2, 1, 0);
    tbl[9]  = mk(1, 5,  51, 50, 2'b00, 0, 0,  16'h0020, 0, 16'h0080, 16'h0020, 2, 0, 0);
    tbl[10] = mk(0, 0,   0,  0, 2'b00, 0, 0,  16'h0000, 0, 16'h0080, 16'h0000, 2, 0, 0);
    tbl[11] = mk(1, 0,  60, 61, 2'b11, 0, 0,  16'h0000, 0, 16'h0081, 16'h0000, 3, 0, 0);
    tbl[12] = mk(0, 0,   0,  0, 2'b00, 0, 0,  16'h0003, 0, 16'h0080, 16'h0001, 2, 0, GE);
    tbl[13] = mk(1, 1,  62, 63, 2'b11, 0, 0,  16'h0000, 0, 16'h0082, 16'h0000, 3, 0, 0);
    tbl[14] = mk(1, 2,  64, 65, 2'b00, 0, 0,  16'h0000, 0, 16'h0082, 16'h0000, 4, 0, 0);
    tbl[15] = mk(1, 4,  66, 67, 2'b11, 1, 64, 16'h0002, 1, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[16] = mk(0, 0,   0,  0, 2'b00, 0, 0,  16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0);

    // Reset state.
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #12;
    chk("rst req",   32'(bus.req_o),       32'h0);
    chk("rst free",  32'(bus.free_o),      32'h0);
    chk("rst count", 32'(bus.count_o),     32'h0);
    chk("rst aerr",  32'(bus.alloc_err_o), 32'h0);
    chk("rst gerr",  32'(bus.grant_err_o), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table.
    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].av, tbl[k].idx, tbl[k].t1, tbl[k].t0, tbl[k].rdy, tbl[k].wv,
            tbl[k].wt, tbl[k].gnt, tbl[k].fl);
      model_step(m_free, m_aerr, m_gerr);
      edge_check($sformatf("vec%0d", k), tbl[k].e_req, tbl[k].e_free, tbl[k].e_cnt,
                 tbl[k].e_aerr, tbl[k].e_gerr);
    end

    // Randomized run against the model.
    for (int k = 0; k < 600; k++) begin
      logic [15:0] g;
      logic [15:0] rq;
      int          mode;
      rq   = model_req();
      mode = int'($urandom_range(0, 3));
      g    = 16'h0;
      if (mode == 1 && rq != 16'h0) begin
        for (int tries = 0; tries < 32 && g == 16'h0; tries++) begin
          int b = int'($urandom_range(0, N - 1));
          if (rq[b]) g[b] = 1'b1;
        end
      end else if (mode == 2) begin
        g = 16'($urandom);
      end else if (mode == 3) begin
        g = rq;
      end
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), g,
            ($urandom_range(0, 31) == 0));
      model_step(m_free, m_aerr, m_gerr);
      edge_check($sformatf("rnd%0d", k), model_req(), m_free, model_count(), m_aerr, m_gerr);
    end

    // Asynchronous reset mid-cycle with occupied slots.
    drive(1, 9, 1, 1, 2'b11, 0, 0, 16'h0, 0);
    model_step(m_free, m_aerr, m_gerr);
    edge_check("prer", model_req(), m_free, model_count(), m_aerr, m_gerr);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst req",   32'(bus.req_o),       32'h0);
    chk("arst free",  32'(bus.free_o),      32'h0);
    chk("arst count", 32'(bus.count_o),     32'h0);
    chk("arst aerr",  32'(bus.alloc_err_o), 32'h0);
    chk("arst gerr",  32'(bus.grant_err_o), 32'h0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 3, 0, 0, 2'b11, 0, 0, 16'h0, 0);
    model_step(m_free, m_aerr, m_gerr);
    edge_check("post", 16'h0008, 16'h0, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
